// File: rtl/memory_stage.sv
// memory_stage: fourth stage of the RV32I pipeline, between execute and writeback.
//
// Takes the execute/memory pipeline register (instruction, PC, ALU result,
// store data) and performs loads and stores against a variable-latency data
// memory using a request/ready handshake. While an access is outstanding the
// stage raises stall_mem to freeze stages 1-4. An access still waiting after
// TIMEOUT wait cycles is aborted. The stage-5 pipeline register lives here;
// z5_output is both the writeback value and the forwarding source.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   ir4/pc4/z4/md4_output      instruction, PC, effective address, store data
//   dmem_rdata, dmem_ready     memory read data and completion strobe
//   dmem_req/we/addr/be/wdata  memory request (req is combinational)
//   stall_mem                  freeze upstream stages this cycle
//   ir5/pc5/z5_output          stage-5 register (ir5 = 0 marks a bubble)
//   misalign_output            one-cycle flag: faulting memory op retired
//   bus_error_output           one-cycle flag: access timed out
module memory_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir4_output,
    input  logic [31:0] pc4_output,
    input  logic [31:0] z4_output,
    input  logic [31:0] md4_output,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic        stall_mem,
    output logic [31:0] ir5_output,
    output logic [31:0] pc5_output,
    output logic [31:0] z5_output,
    output logic        misalign_output,
    output logic        bus_error_output
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nxt_s;

    logic        is_load_s;
    logic        is_store_s;
    logic [2:0]  funct3_s;
    logic [1:0]  addr_lo_s;
    logic        legal_s;
    logic        misaligned_s;
    logic        fault_s;
    logic        valid_mem_s;
    logic        complete_s;
    logic        abort_s;

    // Byte enables for a store; loads always read the whole word.
    function automatic logic [3:0] calc_be(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] a);
        logic [3:0] be;
        if (is_store) begin
            case (f3[1:0])
                2'b00:   be = 4'b0001 << a;
                2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    // Store data replicated across lanes so any byte enable picks the right bits.
    function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] md);
        logic [31:0] wd;
        case (f3[1:0])
            2'b00:   wd = {4{md[7:0]}};
            2'b01:   wd = {2{md[15:0]}};
            default: wd = md;
        endcase
        return wd;
    endfunction

    // Extract and extend the addressed byte/half of the read word.
    function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        case (a)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  v = {{24{b[7]}}, b};
            3'b001:  v = {{16{h[15]}}, h};
            3'b100:  v = {24'h000000, b};
            3'b101:  v = {16'h0000, h};
            default: v = rd;
        endcase
        return v;
    endfunction

    assign funct3_s   = ir4_output[14:12];
    assign addr_lo_s  = z4_output[1:0];
    assign is_load_s  = (ir4_output[6:0] == OP_LOAD);
    assign is_store_s = (ir4_output[6:0] == OP_STORE);

    // Decode funct3 legality and natural alignment of the access.
    always_comb begin
        legal_s      = 1'b0;
        misaligned_s = 1'b0;
        if (is_load_s) begin
            case (funct3_s)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
                default:                                legal_s = 1'b0;
            endcase
        end else if (is_store_s) begin
            case (funct3_s)
                3'b000, 3'b001, 3'b010: legal_s = 1'b1;
                default:                legal_s = 1'b0;
            endcase
        end else begin
            legal_s = 1'b0;
        end
        case (funct3_s[1:0])
            2'b01:   misaligned_s = addr_lo_s[0];
            2'b10:   misaligned_s = (addr_lo_s != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
    end

    assign fault_s     = (is_load_s || is_store_s) && (!legal_s || misaligned_s);
    assign valid_mem_s = (is_load_s || is_store_s) && !fault_s;

    // Upstream is frozen during WAIT, so the request fields stay stable from the
    // held execute-stage register. Reset kills the request immediately.
    assign dmem_req   = reset && ((state_r == ST_WAIT) || valid_mem_s);
    assign dmem_we    = is_store_s;
    assign dmem_addr  = {z4_output[31:2], 2'b00};
    assign dmem_be    = calc_be(is_store_s, funct3_s, addr_lo_s);
    assign dmem_wdata = calc_wdata(funct3_s, md4_output);
    assign stall_mem  = dmem_req && !dmem_ready;

    // Access FSM next-state: issue, wait with timeout count, complete or abort.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        complete_s     = 1'b0;
        abort_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (valid_mem_s) begin
                    if (dmem_ready) begin
                        complete_s = 1'b1;
                    end else begin
                        state_nxt_s    = ST_WAIT;
                        wait_cnt_nxt_s = 8'd1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Ready on the final count still wins over the timeout.
                if (dmem_ready) begin
                    complete_s     = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = 8'd0;
                end else if (wait_cnt_r == TIMEOUT_C) begin
                    abort_s        = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = 8'd0;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Stage-5 pipeline register and one-cycle event flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir5_output       <= 32'd0;
            pc5_output       <= 32'd0;
            z5_output        <= 32'd0;
            misalign_output  <= 1'b0;
            bus_error_output <= 1'b0;
        end else begin
            misalign_output  <= 1'b0;
            bus_error_output <= 1'b0;
            if (complete_s) begin
                ir5_output <= ir4_output;
                pc5_output <= pc4_output;
                z5_output  <= is_load_s ? format_load(funct3_s, addr_lo_s, dmem_rdata)
                                        : z4_output;
            end else if (abort_s) begin
                // The abort cycle is also stalled; it must be checked first.
                ir5_output       <= 32'd0;
                pc5_output       <= pc4_output;
                bus_error_output <= 1'b1;
            end else if (stall_mem) begin
                ir5_output <= 32'd0;
            end else if (fault_s) begin
                ir5_output      <= 32'd0;
                pc5_output      <= pc4_output;
                z5_output       <= z4_output;
                misalign_output <= 1'b1;
            end else begin
                ir5_output <= ir4_output;
                pc5_output <= pc4_output;
                z5_output  <= z4_output;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage (TIMEOUT = 4): directed cases followed by random
// operations, each checked cycle by cycle against a reference model derived
// from the RV32I load/store rules.
module tb_memory_stage;

    localparam int TMO = 4;

    logic        clk;
    logic        reset;
    logic [31:0] ir4_output, pc4_output, z4_output, md4_output, dmem_rdata;
    logic        dmem_ready;
    logic        dmem_req, dmem_we, stall_mem, misalign_output, bus_error_output;
    logic [31:0] dmem_addr, dmem_wdata, ir5_output, pc5_output, z5_output;
    logic [3:0]  dmem_be;

    int n_vec = 0;
    int n_err = 0;

    // model state of the stage-5 register
    logic [31:0] exp_ir5 = 32'd0, exp_pc5 = 32'd0, exp_z5 = 32'd0;
    logic        exp_mis = 1'b0, exp_berr = 1'b0;

    memory_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ir4_output(ir4_output), .pc4_output(pc4_output),
        .z4_output(z4_output), .md4_output(md4_output),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .stall_mem(stall_mem),
        .ir5_output(ir5_output), .pc5_output(pc5_output), .z5_output(z5_output),
        .misalign_output(misalign_output), .bus_error_output(bus_error_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".ir5"},  ir5_output, exp_ir5);
        check({tag, ".pc5"},  pc5_output, exp_pc5);
        check({tag, ".z5"},   z5_output,  exp_z5);
        check({tag, ".mis"},  {31'd0, misalign_output},  {31'd0, exp_mis});
        check({tag, ".berr"}, {31'd0, bus_error_output}, {31'd0, exp_berr});
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] z,
                                             input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> ((z % 4) * 8)) & 32'hFF;
        h = (rd >> (((z % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    // Called at a falling edge; returns at a falling edge. lat = wait cycles
    // before ready (0 = ready in the issue cycle; > TMO never ready).
    task automatic run_op(input string tag, input logic [31:0] ir, input logic [31:0] pc,
                          input logic [31:0] z, input logic [31:0] md, input logic [31:0] rd,
                          input int lat, output int n_stall);
        bit is_ld, is_st, legal, mis, done;
        int sz, c;
        logic [2:0] f3;
        logic [3:0] be;
        logic [31:0] wd;
        f3 = ir[14:12];
        is_ld = (ir[6:0] == 7'b0000011);
        is_st = (ir[6:0] == 7'b0100011);
        legal = is_ld ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                      : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        sz  = 1 << f3[1:0];
        mis = ((z % sz) != 0);
        n_stall = 0;
        ir4_output = ir; pc4_output = pc; z4_output = z; md4_output = md;
        if (!(is_ld || is_st) || !legal || mis) begin
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            #1;
            check({tag, ".req"},   {31'd0, dmem_req},  32'd0);
            check({tag, ".stall"}, {31'd0, stall_mem}, 32'd0);
            @(posedge clk); #1;
            exp_pc5 = pc; exp_z5 = z; exp_berr = 1'b0;
            exp_ir5 = (is_ld || is_st) ? 32'd0 : ir;
            exp_mis = (is_ld || is_st);
            check_regs(tag);
            @(negedge clk);
            return;
        end
        if (!is_st)          be = 4'hF;
        else if (sz == 1)    be = 4'(1 << (z % 4));
        else if (sz == 2)    be = ((z % 4) >= 2) ? 4'hC : 4'h3;
        else                 be = 4'hF;
        wd = (sz == 1) ? (md & 32'hFF) * 32'h0101_0101 :
             (sz == 2) ? (md & 32'hFFFF) * 32'h0001_0001 : md;
        c = 0;
        done = 1'b0;
        while (!done) begin
            dmem_ready = (c == lat);
            dmem_rdata = (c == lat) ? rd : $urandom;
            #1;
            check({tag, ".req"},   {31'd0, dmem_req},  32'd1);
            check({tag, ".stall"}, {31'd0, stall_mem}, {31'd0, (c != lat)});
            check({tag, ".addr"},  dmem_addr, z - (z % 4));
            check({tag, ".we"},    {31'd0, dmem_we},   {31'd0, is_st});
            check({tag, ".be"},    {28'd0, dmem_be},   {28'd0, be});
            if (is_st) check({tag, ".wdata"}, dmem_wdata, wd);
            if (c != lat) n_stall++;
            @(posedge clk); #1;
            exp_mis = 1'b0; exp_berr = 1'b0;
            if (c == lat) begin
                exp_ir5 = ir; exp_pc5 = pc;
                exp_z5 = is_ld ? ref_load(f3, z, rd) : z;
                done = 1'b1;
            end else if (c == TMO) begin
                exp_ir5 = 32'd0; exp_pc5 = pc; exp_berr = 1'b1;
                done = 1'b1;
            end else begin
                exp_ir5 = 32'd0;
            end
            check_regs(tag);
            @(negedge clk);
            c++;
            if (c > 40) begin
                check({tag, ".bound"}, 32'(c), 32'd40);
                done = 1'b1;
            end
        end
        dmem_ready = 1'b0;
    endtask

    function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[6:0] = op;
        r[14:12] = f3;
        return r;
    endfunction

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ALU = 7'b0110011;

    initial begin
        int ns;
        logic [31:0] lw_ir;
        logic [6:0] op;
        reset = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = 32'd0; md4_output = 32'd0;
        lw_ir = mk_ir(LD, 3'd2);
        ir4_output = lw_ir; pc4_output = 32'h0000_0800; z4_output = 32'h0000_0200;
        @(negedge clk);
        #1;
        check("rst.req", {31'd0, dmem_req}, 32'd0);
        check("rst.stall", {31'd0, stall_mem}, 32'd0);
        check_regs("rst");
        @(negedge clk);
        reset = 1'b1;
        // pending lw issues after reset release
        run_op("rst_lw", lw_ir, 32'h0000_0800, 32'h0000_0200, 32'd0, 32'hCAFE_F00D, 0, ns);

        run_op("add", mk_ir(ALU, 3'd0), 32'h0000_0010, 32'h0000_1234, 32'd0, 32'd0, 0, ns);
        check("add.z5c", z5_output, 32'h0000_1234);
        check("add.nstall", 32'(ns), 32'd0);

        run_op("lb", mk_ir(LD, 3'd0), 32'h14, 32'h103, 32'd0, 32'h80FF_0000, 0, ns);
        check("lb.z5c", z5_output, 32'hFFFF_FF80);
        run_op("lbu", mk_ir(LD, 3'd4), 32'h18, 32'h103, 32'd0, 32'h80FF_0000, 0, ns);
        check("lbu.z5c", z5_output, 32'h0000_0080);

        run_op("sh", mk_ir(ST, 3'd1), 32'h1C, 32'h22, 32'hABCD_1234, 32'd0, 3, ns);
        check("sh.nstall", 32'(ns), 32'd3);

        run_op("lw_mis", mk_ir(LD, 3'd2), 32'h20, 32'h41, 32'd0, 32'd0, 0, ns);
        check("lw_mis.z5c", z5_output, 32'h0000_0041);

        run_op("lw_tmo", mk_ir(LD, 3'd2), 32'h24, 32'h300, 32'd0, 32'd0, 99, ns);
        check("lw_tmo.nstall", 32'(ns), 32'(TMO + 1));
        check("lw_tmo.z5c", z5_output, 32'h0000_0041);
        run_op("lw_last", mk_ir(LD, 3'd2), 32'h28, 32'h304, 32'd0, 32'h1357_9BDF, TMO, ns);
        check("lw_last.z5c", z5_output, 32'h1357_9BDF);

        // reset pulled low while waiting
        lw_ir = mk_ir(LD, 3'd2);
        ir4_output = lw_ir; pc4_output = 32'h2C; z4_output = 32'h400;
        dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rstw.req_before", {31'd0, dmem_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("rstw.req", {31'd0, dmem_req}, 32'd0);
        exp_ir5 = 32'd0; exp_pc5 = 32'd0; exp_z5 = 32'd0; exp_mis = 1'b0; exp_berr = 1'b0;
        check_regs("rstw");
        @(negedge clk);
        reset = 1'b1;
        run_op("rstw_lw", lw_ir, 32'h2C, 32'h400, 32'd0, 32'h0BAD_BEEF, 1, ns);

        // random operations
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       op = LD;
                1:       op = ST;
                2:       op = ALU;
                default: op = 7'($urandom_range(0, 127));
            endcase
            run_op("rnd", mk_ir(op, 3'($urandom_range(0, 7))), $urandom, $urandom,
                   $urandom, $urandom, $urandom_range(0, 6), ns);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
